// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module : mux_scan_pkg
// Brief  : Shared state encoding and defaults for the mux scan sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int c_SETTLE_CYCLES_DEFAULT = 2;
  localparam int c_SETTLE_CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module : settle_timer
// Brief  : Modulo-SETTLE_CYCLES counter flagging the last settle cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_tick,
  output logic o_tc
);

  localparam logic [c_SETTLE_CNT_W-1:0] c_LAST = c_SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  logic [c_SETTLE_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_count <= '0;
    end else if (i_tick) begin
      // wrap at the terminal count so the next index starts from zero
      r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module : mux_scan_sequencer
// Brief  : Steps a 4:1 mux select, samples its output into a 4-bit result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic [3:0] result,
  output logic       result_valid,
  input  logic       result_ready
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_index;
  logic [3:0] r_scratch;
  logic [3:0] w_scratch_next;
  logic [3:0] r_result;
  logic       r_valid;
  logic       r_busy;
  logic       w_load;
  logic       w_tick;
  logic       w_tc;
  logic       w_sample;
  logic       w_finish;
  logic       w_handshake;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .i_load(w_load),
    .i_tick(w_tick),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_tick      = 1'b0;
    w_sample    = 1'b0;
    w_finish    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_SCAN;
          w_load = 1'b1;
        end
      end
      ST_SCAN: begin
        w_tick = 1'b1;
        if (w_tc) begin
          w_sample = 1'b1;
          if (r_index == 2'd3) begin
            w_finish = 1'b1;
            w_next   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (r_valid && result_ready) begin
          w_handshake = 1'b1;
          w_load      = continuous;
          w_next      = continuous ? ST_SCAN : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // scratch with the bit for the current index replaced by the live mux value
  always_comb begin
    w_scratch_next          = r_scratch;
    w_scratch_next[r_index] = mux_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index   <= 2'd0;
      r_scratch <= 4'd0;
      r_result  <= 4'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      if (w_sample) begin
        r_scratch <= w_scratch_next;
        r_index   <= r_index + 2'd1;
      end
      if (w_finish) begin
        r_result <= w_scratch_next;
        r_valid  <= 1'b1;
      end
      if (w_handshake) begin
        r_valid <= 1'b0;
        r_index <= 2'd0;
      end
    end
  end

  assign address0     = r_index[0];
  assign address1     = r_index[1];
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// Module : tb_mux_scan_sequencer
// Brief  : Two sequencers (settle 2 and 1) driving gate-delay muxes vs a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_v   [2];
  logic       start_v [2];
  logic       cont_v  [2];
  logic       ready_v [2];
  logic [3:0] in_v    [2];
  logic       mux_v   [2];
  logic       a0_v    [2];
  logic       a1_v    [2];
  logic       busy_v  [2];
  logic       valid_v [2];
  logic [3:0] res_v   [2];

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  initial clk = 1'b0;
  always #200 clk = ~clk;

  // downstream 4:1 mux built from two 50-unit gate levels
  for (genvar j = 0; j < 2; j++) begin : g_mux
    logic [3:0] w_term;
    for (genvar i = 0; i < 4; i++) begin : g_term
      localparam logic [1:0] c_SEL = i;
      assign #50 w_term[i] = in_v[j][i] & (a1_v[j] == c_SEL[1]) & (a0_v[j] == c_SEL[0]);
    end
    assign #50 mux_v[j] = |w_term;
  end

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .continuous(cont_v[0]),
    .mux_out(mux_v[0]), .address0(a0_v[0]), .address1(a1_v[0]), .busy(busy_v[0]),
    .result(res_v[0]), .result_valid(valid_v[0]), .result_ready(ready_v[0])
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .continuous(cont_v[1]),
    .mux_out(mux_v[1]), .address0(a0_v[1]), .address1(a1_v[1]), .busy(busy_v[1]),
    .result(res_v[1]), .result_valid(valid_v[1]), .result_ready(ready_v[1])
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: a scan is a timeline of 4*S edges; bit i is taken at edge (i+1)*S
  int         m_t     [2];
  bit         m_scan  [2];
  bit         m_valid [2];
  logic [3:0] m_vec   [2];
  logic [3:0] m_res   [2];

  function automatic int settle_of(input int j);
    return (j == 0) ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int s;
      s = settle_of(j);
      if (rst_v[j]) begin
        m_t[j] = 0; m_scan[j] = 0; m_valid[j] = 0; m_vec[j] = 4'd0; m_res[j] = 4'd0;
      end else if (m_valid[j]) begin
        if (ready_v[j]) begin
          m_valid[j] = 0;
          m_scan[j]  = cont_v[j];
          m_t[j]     = 0;
        end
      end else if (m_scan[j]) begin
        m_t[j]++;
        if (m_t[j] % s == 0) m_vec[j][m_t[j]/s - 1] = in_v[j][m_t[j]/s - 1];
        if (m_t[j] == 4*s) begin
          m_res[j]   = m_vec[j];
          m_valid[j] = 1;
          m_scan[j]  = 0;
        end
      end else if (start_v[j]) begin
        m_scan[j] = 1;
        m_t[j]    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 2; j++) begin
        int ea;
        ea = m_scan[j] ? m_t[j] / settle_of(j) : 0;
        check_eq($sformatf("s%0d addr", j), {6'd0, a1_v[j], a0_v[j]}, 8'(ea[1:0]));
        check_eq($sformatf("s%0d busy", j), {7'd0, busy_v[j]}, {7'd0, m_scan[j] | m_valid[j]});
        check_eq($sformatf("s%0d valid", j), {7'd0, valid_v[j]}, {7'd0, m_valid[j]});
        check_eq($sformatf("s%0d result", j), {4'd0, res_v[j]}, {4'd0, m_res[j]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < 2; j++) begin
      rst_v[j] = 1'b1; start_v[j] = 1'b0; cont_v[j] = 1'b0; ready_v[j] = 1'b0; in_v[j] = 4'd0;
    end
    cyc(2);
    chk_en = 1'b1;
    check_eq("reset result", {4'd0, res_v[0]}, 8'h00);
    check_eq("reset busy", {7'd0, busy_v[0]}, 8'h00);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    cyc(1);

    // single scan with back-pressure
    in_v[0] = 4'b1010; start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    cyc(7);
    check_eq("single valid early", {7'd0, valid_v[0]}, 8'h00);
    cyc(1);
    check_eq("single valid", {7'd0, valid_v[0]}, 8'h01);
    check_eq("single result", {4'd0, res_v[0]}, 8'h0A);
    in_v[0] = 4'b0101;
    cyc(5);
    check_eq("bp result", {4'd0, res_v[0]}, 8'h0A);
    check_eq("bp valid", {7'd0, valid_v[0]}, 8'h01);
    check_eq("bp addr", {6'd0, a1_v[0], a0_v[0]}, 8'h00);
    ready_v[0] = 1'b1;
    cyc(1);
    check_eq("hs busy", {7'd0, busy_v[0]}, 8'h00);
    check_eq("hs keep result", {4'd0, res_v[0]}, 8'h0A);
    ready_v[0] = 1'b0;
    cyc(2);

    // continuous scanning, inputs change mid-scan
    in_v[0] = 4'b0110; cont_v[0] = 1'b1; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    cyc(8);
    check_eq("cont result", {4'd0, res_v[0]}, 8'h06);
    cyc(9);
    check_eq("cont period", {7'd0, valid_v[0]}, 8'h01);
    cyc(4);
    in_v[0] = 4'b1001;
    cyc(22);
    cont_v[0] = 1'b0;
    cyc(12);

    // reset in the middle of a scan at index 2
    in_v[0] = 4'b1100; start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    cyc(4);
    check_eq("mid addr", {6'd0, a1_v[0], a0_v[0]}, 8'h02);
    rst_v[0] = 1'b1;
    cyc(1);
    check_eq("mid rst busy", {7'd0, busy_v[0]}, 8'h00);
    check_eq("mid rst addr", {6'd0, a1_v[0], a0_v[0]}, 8'h00);
    rst_v[0] = 1'b0; in_v[0] = 4'b0011; start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    cyc(8);
    check_eq("post rst result", {4'd0, res_v[0]}, 8'h03);
    ready_v[0] = 1'b1;
    cyc(2);

    // settle of one cycle, start held high
    in_v[1] = 4'b1111; start_v[1] = 1'b1;
    cyc(1);
    cyc(4);
    check_eq("s1 result", {4'd0, res_v[1]}, 8'h0F);
    check_eq("s1 valid", {7'd0, valid_v[1]}, 8'h01);
    ready_v[1] = 1'b1;
    cyc(12);
    start_v[1] = 1'b0;
    cyc(6);

    // randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < 2; j++) begin
        rst_v[j]   = ($urandom_range(0, 79) == 0);
        start_v[j] = ($urandom_range(0, 3) == 0);
        cont_v[j]  = $urandom_range(0, 1) != 0;
        ready_v[j] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 2) == 0) in_v[j] = 4'($urandom_range(0, 15));
      end
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles each address is held before mux output is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one scan of the four mux inputs; sampled only in IDLE.
REQ-005 continuous  input  1  when 1 at result handshake, next scan begins automatically.
REQ-006 mux_out  input  1  output of the downstream 4:1 multiplexer.
REQ-007 address0  output  1  mux select LSB, registered.
REQ-008 address1  output  1  mux select MSB, registered.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 result  output  4  captured vector, bit i = mux_out sampled with address i.
REQ-011 result_valid  output  1  result holds a completed scan.
REQ-012 result_ready  input  1  consumer accepts result when high with result_valid.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, HOLD; one-hot or binary encoding from the shared package.
REQ-014 IDLE: address = 2'b00; start = 1 at an edge SHALL move to SCAN with index 0 and settle count 0.
REQ-015 SCAN: {address1,address0} SHALL equal the current index for exactly SETTLE_CYCLES cycles per index.
REQ-016 On the last settle cycle of index i, mux_out SHALL be written to scratch[i] and the index incremented, modulo 4.
REQ-017 After index 3 is sampled, result SHALL load scratch with bit 3 = mux_out, result_valid SHALL go 1, state SHALL become HOLD; address returns to 2'b00.
REQ-018 Latency: start accepted at edge k -> result_valid = 1 after edge k + 4*SETTLE_CYCLES.
REQ-019 HOLD: result and result_valid SHALL remain stable until result_valid & result_ready at an edge.
REQ-020 On handshake in HOLD: result_valid SHALL clear; continuous = 1 -> SCAN at index 0, else IDLE.
REQ-021 result_ready asserted during SCAN or IDLE SHALL have no effect.
REQ-022 start SHALL be ignored in SCAN and HOLD; no queuing.
REQ-023 Continuous throughput: one result per 4*SETTLE_CYCLES + 1 cycles when result_ready is held high.
REQ-024 result SHALL keep its last value after handshake until the next scan completes.
REQ-025 Index and settle counter SHALL wrap without overflow; settle counter width 4 bits.

Reset
REQ-026 reset = 1 at an edge SHALL force IDLE, address0 = 0, address1 = 0, busy = 0, result = 4'b0000, result_valid = 0, scratch = 0, counters = 0, in any state including mid-scan.
REQ-027 reset SHALL take priority over start and result_ready in the same cycle.

Structure
REQ-028 State encodings and SETTLE_CYCLES default SHALL live in shared package mux_scan_pkg.
REQ-029 Settle counting SHALL be one sub-module settle_timer (load, tick, terminal-count output).
REQ-030 No combinational path from any input to any output; all outputs registered.

Verification
REQ-031 Bench clock period SHALL be 400 time units so gate-delay mux (two 50-unit gate levels) settles within one cycle; bench SHALL instantiate the gate-level mux downstream.
REQ-032 Single scan, SETTLE_CYCLES=2, inputs {in3,in2,in1,in0}=4'b1010, start pulse at edge k -> result=4'b1010, result_valid=1 after edge k+8, busy=0 after the handshake edge.
REQ-033 Back-pressure: result_ready low 5 cycles after valid, inputs changed to 4'b0101 -> result stays 4'b1010, valid stays 1, address stays 2'b00.
REQ-034 Continuous: continuous=1, result_ready=1, inputs 4'b0110 -> successive results 4'b0110 every 9 cycles; inputs changed to 4'b1001 mid-scan -> only indices sampled after the change reflect it.
REQ-035 Reset mid-scan at index 2 -> next edge all outputs zero, state IDLE; start afterwards yields correct full scan.
REQ-036 SETTLE_CYCLES=1, inputs 4'b1111, start held high continuously with continuous=0 -> result 4'b1111 after edge k+4; start during SCAN ignored; new scan only once IDLE reached.
